// File: rtl/pll_spi_responder_if.sv
// SPI pin bundle for the PLL programming port (CPOL=0, active-low chip select).
// Master drives clock, select and MOSI; the responder drives MISO.
// The interface holds only wires; timing lives in the endpoints.
interface pll_spi_responder_if;
  logic spi_clk;
  logic spi_cs_INV;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_cs_INV, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_cs_INV, input spi_mosi, output spi_miso);
endinterface

// File: rtl/pll_spi_responder.sv
// SPI register responder: 32-bit LSB-first frames (addr [3:0], data [31:4]) into a register file.
// Latency: register update / strobe SYNC_STAGES+1 sysclk after the pin cs rise; frame_err same.
// No backpressure: the SPI master owns timing, each spi_clk phase must last >= 2 sysclk periods.
module pll_spi_responder #(
  parameter int         NUM_REGS    = 3,
  parameter logic [3:0] ADDR_READ   = 4'hE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     sysclk,
  input  logic                     reset_INV,
  pll_spi_responder_if.slave       spi,
  input  logic [27:0]              status_in,
  output logic [NUM_REGS*28-1:0]   reg_data,
  output logic [NUM_REGS-1:0]      reg_wr_strobe,
  output logic                     frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             rst_ff;
  logic                   rst_sync_n;
  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
  logic                   clk_prev, cs_prev;
  logic                   clk_s, cs_s, mosi_s;
  logic                   clk_rise, clk_fall, cs_rise, cs_fall;
  logic [5:0]             count;
  logic [31:0]            rx, tx, tx_load;
  logic [3:0]             sel;
  logic                   wr_en, sel_en, err_en;

  // Reset asserts asynchronously and releases on a sysclk edge.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) rst_ff <= 2'b00;
    else            rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_sync_n = rst_ff[1];

  // Pin synchronisers; select idles high so reset never fakes a cs fall.
  always_ff @(posedge sysclk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      clk_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      clk_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi.spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_INV};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      clk_prev  <= clk_s;
      cs_prev   <= cs_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev;
  assign clk_fall = ~clk_s & clk_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  // State register.
  always_ff @(posedge sysclk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next-state: select edges frame the transfer, decode lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = DECODE;
      DECODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame decode at the cs rise; its effects are registered into the DECODE cycle.
  always_comb begin
    wr_en  = 1'b0;
    sel_en = 1'b0;
    err_en = 1'b0;
    if (state == SHIFT && cs_rise) begin
      if (count != 6'd32)                 err_en = 1'b1;
      else if (rx[3:0] < 4'(NUM_REGS))    wr_en  = 1'b1;
      else if (rx[3:0] == ADDR_READ)      sel_en = 1'b1;
    end
  end

  assign spi.spi_miso = (state == SHIFT) ? tx[0] : 1'b0;

  // Readback word chosen by the select latched from an earlier frame.
  always_comb begin
    tx_load = '0;
    if (sel == 4'hF) tx_load = {status_in, 4'hF};
    for (int n = 0; n < NUM_REGS; n++) begin
      if (sel == n[3:0]) tx_load = {reg_data[28*n +: 28], sel};
    end
  end

  // Shift engine and register file; registers only change on a decoded frame.
  always_ff @(posedge sysclk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      reg_data      <= '0;
      reg_wr_strobe <= '0;
      frame_err     <= 1'b0;
      sel           <= 4'h0;
      count         <= '0;
      rx            <= '0;
      tx            <= '0;
    end else begin
      reg_wr_strobe <= '0;
      frame_err     <= err_en;
      for (int n = 0; n < NUM_REGS; n++) begin
        if (wr_en && rx[3:0] == n[3:0]) begin
          reg_data[28*n +: 28] <= rx[31:4];
          reg_wr_strobe[n]     <= 1'b1;
        end
      end
      if (sel_en) sel <= rx[7:4];
      if (state == IDLE && cs_fall) begin
        count <= '0;
        rx    <= '0;
        tx    <= tx_load;
      end else if (state == SHIFT && !cs_rise) begin
        if (clk_rise) begin
          if (count < 6'd32)  rx[count[4:0]] <= mosi_s;
          if (count != 6'd33) count <= count + 6'd1;
        end
        if (clk_fall) tx <= {1'b0, tx[31:1]};
      end
    end
  end

endmodule

// File: tb/tb_pll_spi_responder.sv
// Bench for pll_spi_responder: directed frames plus random frames vs a register-file model.
// Sysclk period 10 ns, spi_clk = sysclk/4, random start phase per frame.
// MISO is sampled just before each falling spi_clk; pulses sampled 1 ns after sysclk edges.
module tb_pll_spi_responder;
  localparam int NUM = 3;

  logic              sysclk = 1'b0;
  logic              reset_INV;
  logic [27:0]       status_in;
  logic [NUM*28-1:0] reg_data;
  logic [NUM-1:0]    reg_wr_strobe;
  logic              frame_err;

  pll_spi_responder_if spi_if ();

  pll_spi_responder #(.NUM_REGS(NUM), .ADDR_READ(4'hE), .SYNC_STAGES(2)) dut (
    .sysclk        (sysclk),
    .reset_INV     (reset_INV),
    .spi           (spi_if),
    .status_in     (status_in),
    .reg_data      (reg_data),
    .reg_wr_strobe (reg_wr_strobe),
    .frame_err     (frame_err)
  );

  always #5 sysclk = ~sysclk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: register values and the read select, updated per whole frame.
  logic [27:0] m_regs [NUM];
  logic [3:0]  m_sel;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_tx();
    if (m_sel < 4'(NUM)) return {m_regs[m_sel[1:0]], m_sel};
    if (m_sel == 4'hF)   return {status_in, 4'hF};
    return 32'h0;
  endfunction

  function automatic logic [NUM*28-1:0] model_regs();
    return {m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  // One SPI transfer of nbits clocks; also watches the pulses after cs rise.
  task automatic do_frame(input logic [31:0] word, input int nbits, output logic [31:0] rd,
                          output logic [NUM-1:0] stb_or, output int stb_cyc, output int err_cyc,
                          output int lat);
    rd = '0; stb_or = '0; stb_cyc = 0; err_cyc = 0; lat = 0;
    @(posedge sysclk);
    #($urandom_range(2, 9));
    spi_if.spi_cs_INV = 1'b0;
    #30;
    for (int i = 0; i < nbits; i++) begin
      spi_if.spi_mosi = (i < 32) ? word[i] : 1'b0;
      #20;
      spi_if.spi_clk = 1'b1;
      #19;
      if (i < 32) rd[i] = spi_if.spi_miso;
      #1;
      spi_if.spi_clk = 1'b0;
    end
    #20;
    @(posedge sysclk);
    #1;
    spi_if.spi_cs_INV = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge sysclk);
      #1;
      stb_or = stb_or | reg_wr_strobe;
      if (|reg_wr_strobe) stb_cyc++;
      if (frame_err) err_cyc++;
      if ((|reg_wr_strobe || frame_err) && lat == 0) lat = k;
    end
    #20;
  endtask

  task automatic run_frame(input logic [31:0] word, input int nbits, input string tag,
                           output logic [31:0] rd);
    logic [31:0]    exp_rd;
    logic [NUM-1:0] exp_stb, stb_or;
    bit             exp_err;
    int             scyc, ecyc, lat;
    logic [3:0]     a;
    exp_rd = model_tx();
    do_frame(word, nbits, rd, stb_or, scyc, ecyc, lat);
    exp_stb = '0;
    exp_err = (nbits != 32);
    a = word[3:0];
    if (!exp_err) begin
      if (a < 4'(NUM)) begin
        m_regs[a[1:0]] = word[31:4];
        exp_stb[a[1:0]] = 1'b1;
      end else if (a == 4'hE) begin
        m_sel = word[7:4];
      end
    end
    if (nbits >= 32) chk({tag, ".miso"}, rd, exp_rd);
    chk({tag, ".strobe"}, stb_or, exp_stb);
    chk({tag, ".strobe_cycles"}, scyc, (exp_stb != 0) ? 1 : 0);
    chk({tag, ".err_cycles"}, ecyc, exp_err ? 1 : 0);
    if (exp_stb != 0 || exp_err) chk({tag, ".latency"}, lat, 3);
    chk({tag, ".regs"}, reg_data, model_regs());
  endtask

  initial begin
    logic [31:0] rd, w;
    int          nb, pick;
    reset_INV = 1'b0;
    spi_if.spi_clk = 1'b0;
    spi_if.spi_cs_INV = 1'b1;
    spi_if.spi_mosi = 1'b0;
    status_in = 28'h0;
    for (int n = 0; n < NUM; n++) m_regs[n] = '0;
    m_sel = 4'h0;
    #25;
    reset_INV = 1'b1;
    #50;
    @(negedge sysclk);
    chk("reset.regs", reg_data, '0);
    chk("reset.strobe", reg_wr_strobe, '0);
    chk("reset.err", frame_err, 1'b0);
    chk("reset.miso", spi_if.spi_miso, 1'b0);

    // Write reg1.
    run_frame(32'h1234_5671, 32, "t1", rd);
    chk("t1.reg1", reg_data[55:28], 28'h1234567);
    chk("t1.reg0", reg_data[27:0], 28'h0);
    chk("t1.reg2", reg_data[83:56], 28'h0);

    // Select reg1 for readback, then read it with an ignored address.
    run_frame(32'h0000_001E, 32, "t2a", rd);
    run_frame(32'h0000_000D, 32, "t2b", rd);
    chk("t2.readback", rd, 32'h1234_5671);

    // Status readback, then an unmapped select reads zero.
    status_in = 28'hABCDEF0;
    run_frame(32'h0000_00FE, 32, "t3a", rd);
    run_frame(32'h0000_005E, 32, "t3b", rd);
    chk("t3.status", rd, 32'hABCD_EF0F);
    run_frame(32'h0000_000D, 32, "t3c", rd);
    chk("t3.zero", rd, 32'h0);

    // Malformed lengths, then a good frame.
    run_frame(32'hAAAA_AAA0, 31, "t4a", rd);
    run_frame(32'h5555_5550, 33, "t4b", rd);
    run_frame(32'h0C0F_FEE0, 32, "t4c", rd);
    chk("t4.reg0", reg_data[27:0], 28'h0C0FFEE);

    // Reset in the middle of a frame.
    @(posedge sysclk);
    #3;
    spi_if.spi_cs_INV = 1'b0;
    #30;
    for (int i = 0; i < 16; i++) begin
      spi_if.spi_mosi = i[0];
      #20 spi_if.spi_clk = 1'b1;
      #20 spi_if.spi_clk = 1'b0;
    end
    reset_INV = 1'b0;
    #1;
    chk("t5.regs", reg_data, '0);
    chk("t5.strobe", reg_wr_strobe, '0);
    chk("t5.err", frame_err, 1'b0);
    chk("t5.miso", spi_if.spi_miso, 1'b0);
    spi_if.spi_cs_INV = 1'b1;
    #30;
    reset_INV = 1'b1;
    for (int n = 0; n < NUM; n++) m_regs[n] = '0;
    m_sel = 4'h0;
    #50;
    run_frame(32'hFFFF_FFF2, 32, "t5", rd);
    chk("t5.reg2", reg_data[83:56], 28'hFFFFFFF);

    // Random frames against the model.
    for (int f = 0; f < 300; f++) begin
      status_in = 28'($urandom);
      w = $urandom;
      pick = $urandom_range(0, 9);
      if (pick < 5)       w[3:0] = 4'($urandom_range(0, NUM - 1));
      else if (pick < 7)  w[3:0] = 4'hE;
      if (pick == 6)      w[7:4] = 4'hF;
      nb = 32;
      if ($urandom_range(0, 9) == 0) nb = ($urandom_range(0, 1) != 0) ? 33 : 31;
      run_frame(w, nb, "rnd", rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
